ibfu_dif: RTL and testbench
===========================

IBFU_DIF -- requirements
Module: ibfu_dif

Interface
REQ-001 Parameter SCALE, default 0: 1 means both outputs are halved with rounding (per-stage 1/2 scaling for IFFT).
REQ-002 Parameter INVERSE, default 0: 1 means the twiddle is conjugated before multiplication (inverse transform).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_a/in_b/twiddle_factor carry a valid butterfly operand set.
REQ-006 in_ready  output  1  the block accepts an operand set this cycle.
REQ-007 in_a, in_b  input  32 each  complex Q1.15 operands: [15:0] real, [31:16] imaginary, two's complement.
REQ-008 twiddle_factor  input  32  complex Q1.15 twiddle, same packing as in_a.
REQ-009 out_valid  output  1  out_a/out_b hold a valid result.
REQ-010 out_ready  input  1  the downstream consumer takes the result this cycle.
REQ-011 out_a, out_b  output  32 each  complex Q1.15 results, same packing.
REQ-012 overflow  output  1  sticky saturation flag.
REQ-013 clear_ovf  input  1  synchronous clear of overflow.

Function
REQ-014 The block SHALL compute a decimation-in-frequency butterfly: out_a = S(a+b), out_b = S((a-b)*w'), with w' = conj(w) when INVERSE=1 and w' = w otherwise.
REQ-015 The pipeline SHALL have three register stages: S1 add/sub at 17 bits, S2 complex multiply, S3 round/scale/saturate. Latency from acceptance to out_valid SHALL be 3 cycles.
REQ-016 Pipeline advance SHALL be adv = ~out_valid | out_ready. All three stages SHALL shift only when adv is 1. in_ready SHALL equal adv combinationally.
REQ-017 A transfer SHALL occur on in_valid & in_ready or on out_valid & out_ready. Each stage SHALL carry a valid bit. Bubbles SHALL propagate and SHALL NOT be collapsed.
REQ-018 While out_valid=1 and out_ready=0, out_a, out_b and out_valid SHALL hold stable, and no stage SHALL change.
REQ-019 S1 SHALL form sum = a+b and diff = a-b per component as signed 17-bit values. Twiddle SHALL be registered alongside, conjugated if INVERSE=1 (imaginary 0x8000 negates to +32768, held at 17 bits).
REQ-020 S2 SHALL form re = dr*wr - di*wi and im = dr*wi + di*wr, using signed 17x17 products into a signed 35-bit accumulator, with no intermediate truncation.
REQ-021 For the product path, S3 SHALL use shift k = 15+SCALE. It SHALL add 2^(k-1) (round half up), arithmetic-shift right by k, then saturate to [-32768, 32767].
REQ-022 For the sum path, S3 SHALL pass through when SCALE=0, and SHALL compute (sum+1)>>>1 when SCALE=1. It SHALL then saturate to 16 bits.
REQ-023 Any saturation event on a result leaving S3 SHALL set overflow on the next edge. clear_ovf SHALL clear overflow. If both happen in the same cycle, set SHALL win.
REQ-024 overflow SHALL only be set by valid data. Bubbles SHALL never set it.
REQ-025 Throughput SHALL be one butterfly per cycle while out_ready=1.

Reset
REQ-026 While rst_n=0, all stage valid bits, out_valid, out_a, out_b and overflow SHALL be 0, taking effect immediately and independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight data. No partial result SHALL appear after release.
REQ-028 After reset release, in_ready SHALL be 1, and the first accepted set SHALL appear 3 cycles later.

Verification
REQ-029 Basic, SCALE=0, INVERSE=0: a=0x0000_4000, b=0x0000_2000, w=0x0000_7FFF -> 3 cycles later out_a=0x0000_6000, out_b=0x0000_2000, overflow=0.
REQ-030 Conjugation: a=0, b=0x0000_4000, w=0x8000_0000. With INVERSE=0 -> out_b=0x4000_0000; with INVERSE=1 -> out_b=0xC000_0000. In both cases out_a=0x0000_4000.
REQ-031 Saturation: a=b=0x0000_7FFF, w=0x0000_7FFF. With SCALE=0 -> out_a=0x0000_7FFF, overflow=1, and it stays 1 until a clear_ovf pulse. With SCALE=1 -> out_a=0x0000_7FFF, overflow=0.
REQ-032 Backpressure: stream 6 operand sets while holding out_ready=0 for 5 cycles -> in_ready drops after 3 sets are in flight; results are held stable; all 6 results arrive in order with no loss or duplication.
REQ-033 Reset mid-stream: assert rst_n=0 with 3 valid sets in flight -> out_valid=0 and overflow=0 immediately; after release, no stale result appears and in_ready=1.
REQ-034 Random streaming: 10k random operand sets with random in_valid/out_ready, checked against a bit-exact reference model for both SCALE and INVERSE settings -> zero mismatches.

Source files
------------

// File: rtl/ibfu_dif.sv
// Radix-2 decimation-in-frequency butterfly, Q1.15 complex, three register stages
// with a single stall signal shared by every stage.
module ibfu_dif #(
   parameter int SCALE   = 0,
   parameter int INVERSE = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [31:0] twiddle_factor,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic        overflow,
   input  logic        clear_ovf
);

   localparam int               K   = 15 + SCALE;
   localparam logic signed [34:0] RND = 35'sd1 <<< (K - 1);

   function automatic logic signed [16:0] sx17(input logic [15:0] x);
      return {x[15], x};
   endfunction

   function automatic logic signed [34:0] sx35(input logic signed [16:0] x);
      return {{18{x[16]}}, x};
   endfunction

   // bit 16 of the result flags that clipping occurred
   function automatic logic [16:0] sat16(input logic signed [34:0] x);
      if (x > 35'sd32767)
         return {1'b1, 16'h7FFF};
      else if (x < -35'sd32768)
         return {1'b1, 16'h8000};
      else
         return {1'b0, x[15:0]};
   endfunction

   logic adv;
   logic out_valid_q, ovf_q;
   logic [31:0] out_a_q, out_b_q;

   assign adv       = ~out_valid_q | out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign overflow  = ovf_q;

   // stage 1: add/sub and twiddle capture
   logic signed [16:0] a_re, a_im, b_re, b_im, w_im_raw, w_im_c;
   assign a_re     = sx17(in_a[15:0]);
   assign a_im     = sx17(in_a[31:16]);
   assign b_re     = sx17(in_b[15:0]);
   assign b_im     = sx17(in_b[31:16]);
   assign w_im_raw = sx17(twiddle_factor[31:16]);
   assign w_im_c   = (INVERSE != 0) ? -w_im_raw : w_im_raw;

   logic               v1_q;
   logic signed [16:0] s_re_q, s_im_q, d_re_q, d_im_q, w_re_q, w_im_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         s_re_q <= '0;
         s_im_q <= '0;
         d_re_q <= '0;
         d_im_q <= '0;
         w_re_q <= '0;
         w_im_q <= '0;
      end else if (adv) begin
         v1_q   <= in_valid;
         s_re_q <= a_re + b_re;
         s_im_q <= a_im + b_im;
         d_re_q <= a_re - b_re;
         d_im_q <= a_im - b_im;
         w_re_q <= sx17(twiddle_factor[15:0]);
         w_im_q <= w_im_c;
      end
   end

   // stage 2: full-precision complex multiply
   logic signed [34:0] p_re_d, p_im_d;
   assign p_re_d = sx35(d_re_q) * sx35(w_re_q) - sx35(d_im_q) * sx35(w_im_q);
   assign p_im_d = sx35(d_re_q) * sx35(w_im_q) + sx35(d_im_q) * sx35(w_re_q);

   logic               v2_q;
   logic signed [34:0] p_re_q, p_im_q;
   logic signed [16:0] s2_re_q, s2_im_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q    <= 1'b0;
         p_re_q  <= '0;
         p_im_q  <= '0;
         s2_re_q <= '0;
         s2_im_q <= '0;
      end else if (adv) begin
         v2_q    <= v1_q;
         p_re_q  <= p_re_d;
         p_im_q  <= p_im_d;
         s2_re_q <= s_re_q;
         s2_im_q <= s_im_q;
      end
   end

   // stage 3: round half up, scale, saturate
   logic signed [34:0] r_re, r_im, q_re, q_im;
   logic [16:0]        ya_re, ya_im, yb_re, yb_im;
   logic               sat_hit;

   assign r_re = (p_re_q + RND) >>> K;
   assign r_im = (p_im_q + RND) >>> K;
   assign q_re = (SCALE != 0) ? ((sx35(s2_re_q) + 35'sd1) >>> 1) : sx35(s2_re_q);
   assign q_im = (SCALE != 0) ? ((sx35(s2_im_q) + 35'sd1) >>> 1) : sx35(s2_im_q);

   assign ya_re   = sat16(q_re);
   assign ya_im   = sat16(q_im);
   assign yb_re   = sat16(r_re);
   assign yb_im   = sat16(r_im);
   assign sat_hit = v2_q & (ya_re[16] | ya_im[16] | yb_re[16] | yb_im[16]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         ovf_q       <= 1'b0;
      end else begin
         if (adv) begin
            out_valid_q <= v2_q;
            if (v2_q) begin
               out_a_q <= {ya_im[15:0], ya_re[15:0]};
               out_b_q <= {yb_im[15:0], yb_re[15:0]};
            end
         end
         // a new saturation beats a simultaneous clear
         if (adv && sat_hit)
            ovf_q <= 1'b1;
         else if (clear_ovf)
            ovf_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ibfu_dif.sv
// Bench for ibfu_dif: four instances covering every SCALE/INVERSE pairing share one
// stimulus stream; expected results are queued on acceptance and checked by a monitor.
module tb_ibfu_dif;

   logic        clk, rst_n, in_valid, out_ready, clear_ovf;
   logic [31:0] in_a, in_b, twiddle_factor;
   logic [3:0]  in_ready_w, out_valid_w, ovf_w;
   logic [31:0] out_a_w [4];
   logic [31:0] out_b_w [4];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      ibfu_dif #(.SCALE(g % 2), .INVERSE(g / 2)) u_dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .in_valid      (in_valid),
         .in_ready      (in_ready_w[g]),
         .in_a          (in_a),
         .in_b          (in_b),
         .twiddle_factor(twiddle_factor),
         .out_valid     (out_valid_w[g]),
         .out_ready     (out_ready),
         .out_a         (out_a_w[g]),
         .out_b         (out_b_w[g]),
         .overflow      (ovf_w[g]),
         .clear_ovf     (clear_ovf)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0][31:0] a;
      logic [3:0][31:0] b;
      logic [3:0]       sat;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] ovf_acc = '0;
   int         n_checks = 0;
   int         n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference: plain integer arithmetic on the butterfly equations
   function automatic logic [15:0] clamp(input longint x, output bit s);
      s = 1'b0;
      if (x > 32767) begin s = 1'b1; return 16'h7FFF; end
      if (x < -32768) begin s = 1'b1; return 16'h8000; end
      return 16'(x);
   endfunction

   function automatic void model(input logic [31:0] a, b, w, input int sc, inv,
                                 output logic [31:0] oa, ob, output bit sat);
      longint ar, ai, br, bi, wr, wi, sr, si, dr, di, pr, pi;
      logic [15:0] x0, x1, x2, x3;
      bit s0, s1, s2, s3;
      int k;
      ar = longint'($signed(a[15:0]));  ai = longint'($signed(a[31:16]));
      br = longint'($signed(b[15:0]));  bi = longint'($signed(b[31:16]));
      wr = longint'($signed(w[15:0]));  wi = longint'($signed(w[31:16]));
      if (inv != 0) wi = -wi;
      sr = ar + br;  si = ai + bi;
      dr = ar - br;  di = ai - bi;
      pr = dr * wr - di * wi;
      pi = dr * wi + di * wr;
      k  = 15 + sc;
      pr = (pr + (longint'(1) << (k - 1))) >>> k;
      pi = (pi + (longint'(1) << (k - 1))) >>> k;
      if (sc != 0) begin
         sr = (sr + 1) >>> 1;
         si = (si + 1) >>> 1;
      end
      x0 = clamp(sr, s0);  x1 = clamp(si, s1);
      x2 = clamp(pr, s2);  x3 = clamp(pi, s3);
      oa  = {x1, x0};
      ob  = {x3, x2};
      sat = s0 | s1 | s2 | s3;
   endfunction

   task automatic push_exp(input logic [31:0] a, b, w);
      exp_t e;
      logic [31:0] oa, ob;
      bit s;
      for (int g = 0; g < 4; g++) begin
         model(a, b, w, g % 2, g / 2, oa, ob, s);
         e.a[g]   = oa;
         e.b[g]   = ob;
         e.sat[g] = s;
      end
      exp_q.push_back(e);
   endtask

   task automatic drive_cycle(input bit v, input logic [31:0] a, b, w, input bit ordy,
                              output bit acc);
      @(negedge clk);
      in_valid = v;  in_a = a;  in_b = b;  twiddle_factor = w;
      out_ready = ordy;  clear_ovf = 1'b0;
      #1;
      acc = v && in_ready_w[0] && rst_n;
      if (acc) push_exp(a, b, w);
   endtask

   task automatic wait_out(output int lat);
      bit acc;
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, acc);
         if (out_valid_w[0]) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic send_and_wait(input string name, input logic [31:0] a, b, w);
      bit acc;
      int lat;
      drive_cycle(1'b1, a, b, w, 1'b1, acc);
      chk({name, " accepted"}, 32'(acc), 32'd1);
      wait_out(lat);
      chk({name, " latency"}, 32'(lat), 32'd3);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      in_valid = 1'b0;  out_ready = 1'b1;  clear_ovf = 1'b1;
      @(negedge clk);
      clear_ovf = 1'b0;
      ovf_acc   = '0;
   endtask

   task automatic drain();
      bit acc;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++)
         drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, acc);
      chk("drain queue empty", 32'(exp_q.size()), 32'd0);
   endtask

   function automatic logic [15:0] rnd16();
      case ($urandom_range(0, 5))
         0:       return 16'h7FFF;
         1:       return 16'h8000;
         2:       return 16'h0000;
         default: return 16'($urandom);
      endcase
   endfunction

   // monitor: every presented result is compared with the queue head (so a held
   // result is re-checked each stalled cycle); it is popped only on transfer
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && out_valid_w[0]) begin
            if (exp_q.size() == 0) begin
               chk("spurious out_valid", 32'(out_valid_w[0]), 32'd0);
            end else begin
               e = exp_q[0];
               for (int g = 0; g < 4; g++) begin
                  chk($sformatf("out_a[%0d]", g), out_a_w[g], e.a[g]);
                  chk($sformatf("out_b[%0d]", g), out_b_w[g], e.b[g]);
                  chk($sformatf("overflow[%0d]", g), 32'(ovf_w[g]),
                      32'(ovf_acc[g] | e.sat[g]));
               end
               if (out_ready) begin
                  ovf_acc = ovf_acc | e.sat;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int sent, stall_acc;
      logic [31:0] bp_a [6];

      rst_n = 1'b0;  in_valid = 1'b0;  out_ready = 1'b0;  clear_ovf = 1'b0;
      in_a = '0;  in_b = '0;  twiddle_factor = '0;
      #3;
      chk("reset out_valid", 32'(out_valid_w[0]), 32'd0);
      chk("reset overflow", 32'(ovf_w[0]), 32'd0);
      chk("reset out_a", out_a_w[0], 32'h0);
      chk("reset out_b", out_b_w[0], 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("in_ready after reset", 32'(in_ready_w[0]), 32'd1);

      // basic butterfly
      send_and_wait("basic", 32'h0000_4000, 32'h0000_2000, 32'h0000_7FFF);
      chk("basic out_a", out_a_w[0], 32'h0000_6000);
      chk("basic out_b", out_b_w[0], 32'h0000_2000);
      chk("basic overflow", 32'(ovf_w[0]), 32'd0);

      // twiddle conjugation
      send_and_wait("conj", 32'h0, 32'h0000_4000, 32'h8000_0000);
      chk("conj fwd out_b", out_b_w[0], 32'h4000_0000);
      chk("conj inv out_b", out_b_w[2], 32'hC000_0000);
      chk("conj fwd out_a", out_a_w[0], 32'h0000_4000);
      chk("conj inv out_a", out_a_w[2], 32'h0000_4000);

      // saturation and sticky overflow
      send_and_wait("sat", 32'h0000_7FFF, 32'h0000_7FFF, 32'h0000_7FFF);
      chk("sat s0 out_a", out_a_w[0], 32'h0000_7FFF);
      chk("sat s0 overflow", 32'(ovf_w[0]), 32'd1);
      chk("sat s1 out_a", out_a_w[1], 32'h0000_7FFF);
      chk("sat s1 overflow", 32'(ovf_w[1]), 32'd0);
      repeat (4) drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, acc);
      chk("sat overflow sticky", 32'(ovf_w[0]), 32'd1);
      pulse_clear();
      #1;
      chk("overflow cleared", 32'(ovf_w[0]), 32'd0);

      // backpressure: out_ready low for the first 5 cycles
      for (int i = 0; i < 6; i++) bp_a[i] = 32'h0100_0100 * (i + 1);
      sent = 0;
      stall_acc = 0;
      for (int cyc = 0; cyc < 60 && sent < 6; cyc++) begin
         drive_cycle(1'b1, bp_a[sent], 32'h0000_0010, 32'h0000_4000, cyc >= 5, acc);
         if (acc) begin
            sent++;
            if (cyc < 5) stall_acc++;
         end
         if (cyc == 4) chk("bp in_ready stalled", 32'(in_ready_w[0]), 32'd0);
      end
      chk("bp accepted while stalled", 32'(stall_acc), 32'd3);
      chk("bp all sent", 32'(sent), 32'd6);
      drain();

      // reset with three sets in flight
      pulse_clear();
      for (int i = 0; i < 3; i++)
         drive_cycle(1'b1, 32'h0000_7FFF, 32'h0000_7FFF, 32'h0000_7FFF, 1'b1, acc);
      @(negedge clk);
      chk("pre-reset out_valid", 32'(out_valid_w[0]), 32'd1);
      chk("pre-reset overflow", 32'(ovf_w[0]), 32'd1);
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      exp_q.delete();
      ovf_acc = '0;
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("rst out_valid[%0d]", g), 32'(out_valid_w[g]), 32'd0);
         chk($sformatf("rst overflow[%0d]", g), 32'(ovf_w[g]), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post-reset in_ready", 32'(in_ready_w[0]), 32'd1);
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, acc);
         chk("post-reset no stale out", 32'(out_valid_w[0]), 32'd0);
      end

      // random streaming
      pulse_clear();
      sent = 0;
      for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
         drive_cycle($urandom_range(0, 3) != 0, {rnd16(), rnd16()}, {rnd16(), rnd16()},
                     {rnd16(), rnd16()}, $urandom_range(0, 9) < 7, acc);
         if (acc) sent++;
      end
      chk("random sets sent", 32'(sent), 32'd10000);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
